ad_ip_jesd204_tpl_dac_sync_ctrl: RTL

Link-clock-domain sequencer that arms, triggers and releases the DAC transport-layer datapath synchronisation. It accepts software arm/disarm/trigger requests or an external sync edge, applies a programmable delay, and waits for link_ready. It then issues a single-cycle dac_sync pulse to the TPL DAC core, reporting status and timeout back to the register map. It sits between the TPL DAC regmap (requests already in link_clk domain) and the TPL DAC core.

---
 rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// ad_ip_jesd204_tpl_dac_sync_ctrl
// Link-clock sequencer for the TPL DAC datapath sync. Software arms the block,
// then a manual request or an external sync rising edge starts a programmable
// delay. After the delay, and once the link is ready, one dac_sync pulse goes
// to the TPL core. An armed wait that runs too long returns to idle and sets a
// sticky timeout flag.

module ad_ip_jesd204_tpl_dac_sync_ctrl #(
  parameter int EXT_SYNC      = 0,
  parameter int DELAY_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     link_clk,
  input  logic                     link_resetn,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     manual_sync,
  input  logic                     ext_sync_en,
  input  logic [DELAY_WIDTH-1:0]   sync_delay,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic                     dac_sync_in,
  input  logic                     link_ready,
  output logic                     dac_sync,
  output logic                     armed,
  output logic                     running,
  output logic                     timeout_err,
  output logic [COUNT_WIDTH-1:0]   sync_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic                     EXT_EN   = (EXT_SYNC != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WAIT_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DELAY_WIDTH-1:0]   DLY_ONE  = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]   CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state_r;
  state_t                     next_state_s;
  logic [TIMEOUT_WIDTH-1:0]   wait_cnt_r;
  logic [TIMEOUT_WIDTH-1:0]   next_wait_s;
  logic [DELAY_WIDTH-1:0]     delay_cnt_r;
  logic [DELAY_WIDTH-1:0]     next_delay_s;
  logic                       next_terr_s;
  logic                       pulse_s;
  logic                       sync_in_d_r;
  logic                       trigger_s;
  logic                       timeout_hit_s;
  logic                       dac_sync_r;
  logic                       armed_r;
  logic                       running_r;
  logic                       timeout_err_r;
  logic [COUNT_WIDTH-1:0]     sync_count_r;

  // Trigger qualification: software request or a rising edge of the external sync.
  always_comb begin
    trigger_s     = manual_sync | (EXT_EN & ext_sync_en & dac_sync_in & ~sync_in_d_r);
    timeout_hit_s = (timeout_cycles != {TIMEOUT_WIDTH{1'b0}}) &&
                    (wait_cnt_r == (timeout_cycles - WAIT_ONE));
  end

  // Next-state decode: disarm beats arm, arm beats any trigger, in every state.
  always_comb begin
    next_state_s = state_r;
    next_wait_s  = wait_cnt_r;
    next_delay_s = delay_cnt_r;
    next_terr_s  = timeout_err_r;
    pulse_s      = 1'b0;
    if (disarm) begin
      next_state_s = ST_IDLE;
      next_wait_s  = {TIMEOUT_WIDTH{1'b0}};
      next_delay_s = {DELAY_WIDTH{1'b0}};
    end else if (arm) begin
      // Re-arming from any state restarts the wait and drops a pending delay.
      next_state_s = ST_ARMED;
      next_wait_s  = {TIMEOUT_WIDTH{1'b0}};
      next_delay_s = {DELAY_WIDTH{1'b0}};
      if (state_r == ST_IDLE) begin
        next_terr_s = 1'b0;
      end else begin
        next_terr_s = timeout_err_r;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_wait_s = {TIMEOUT_WIDTH{1'b0}};
        end
        ST_ARMED: begin
          if (trigger_s) begin
            // A trigger on the timeout cycle still wins.
            next_state_s = ST_DELAY;
            next_delay_s = sync_delay;
            next_wait_s  = {TIMEOUT_WIDTH{1'b0}};
          end else if (timeout_hit_s) begin
            next_state_s = ST_IDLE;
            next_terr_s  = 1'b1;
            next_wait_s  = {TIMEOUT_WIDTH{1'b0}};
          end else begin
            next_wait_s = wait_cnt_r + WAIT_ONE;
          end
        end
        ST_DELAY: begin
          if (delay_cnt_r != {DELAY_WIDTH{1'b0}}) begin
            next_delay_s = delay_cnt_r - DLY_ONE;
          end else if (link_ready) begin
            next_state_s = ST_RUN;
            pulse_s      = 1'b1;
          end else begin
            // Delay expired but the link is not up: hold with no timeout.
            next_state_s = ST_DELAY;
          end
        end
        ST_RUN: begin
          next_state_s = ST_RUN;
        end
        default: begin
          next_state_s = ST_IDLE;
          next_wait_s  = {TIMEOUT_WIDTH{1'b0}};
          next_delay_s = {DELAY_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, counters, edge history and registered status outputs.
  always_ff @(posedge link_clk or negedge link_resetn) begin
    if (!link_resetn) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= {TIMEOUT_WIDTH{1'b0}};
      delay_cnt_r   <= {DELAY_WIDTH{1'b0}};
      sync_in_d_r   <= 1'b1;
      dac_sync_r    <= 1'b0;
      armed_r       <= 1'b0;
      running_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      sync_count_r  <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r       <= next_state_s;
      wait_cnt_r    <= next_wait_s;
      delay_cnt_r   <= next_delay_s;
      sync_in_d_r   <= dac_sync_in;
      dac_sync_r    <= pulse_s;
      armed_r       <= (next_state_s == ST_ARMED) || (next_state_s == ST_DELAY);
      running_r     <= (next_state_s == ST_RUN);
      timeout_err_r <= next_terr_s;
      if (pulse_s) begin
        sync_count_r <= sync_count_r + CNT_ONE;
      end else begin
        sync_count_r <= sync_count_r;
      end
    end
  end

  assign dac_sync    = dac_sync_r;
  assign armed       = armed_r;
  assign running     = running_r;
  assign timeout_err = timeout_err_r;
  assign sync_count  = sync_count_r;

endmodule
